// File: rtl/imem_boot_loader_if.sv
// rtl/imem_boot_loader_if.sv - byte-stream input and instruction-memory write bus of the boot loader
interface imem_boot_loader_if;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;

  // loader side: consumes the byte stream, drives the memory write port
  modport slave (
    input  in_valid,
    input  in_data,
    output in_ready,
    output mem_we,
    output mem_addr,
    output mem_wdata
  );

  // host side: sources the byte stream, observes the memory write port
  modport master (
    output in_valid,
    output in_data,
    input  in_ready,
    input  mem_we,
    input  mem_addr,
    input  mem_wdata
  );
endinterface

// File: rtl/imem_boot_loader.sv
// rtl/imem_boot_loader.sv - boot loader assembling LE words into imem; optional trailing XOR checksum via LOADER_CHECKSUM_EN
module imem_boot_loader #(
  parameter int WORDS = 64
) (
  input  logic                clk,
  input  logic                rst,
  imem_boot_loader_if.slave   bus,
  output logic                cpu_rst_n,
  output logic                done,
  output logic                error,
  output logic [15:0]         words_loaded
);

  localparam logic [2:0] HDR0   = 3'd0;
  localparam logic [2:0] HDR1   = 3'd1;
  localparam logic [2:0] LENCHK = 3'd2;
  localparam logic [2:0] DATA   = 3'd3;
  localparam logic [2:0] WRITE  = 3'd4;
  localparam logic [2:0] CSUM   = 3'd5;
  localparam logic [2:0] DONE   = 3'd6;
  localparam logic [2:0] ERROR  = 3'd7;

  localparam logic [15:0] MAX_LEN = 16'(WORDS);

  logic [2:0]  state;
  logic [15:0] len;
  logic [15:0] word_idx;
  logic [1:0]  byte_idx;
  logic [23:0] asm_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic        xfer;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]  csum;
`endif

  // in_ready is gated by rst so it reads 0 throughout the reset cycle
  assign bus.in_ready = rst && ((state == HDR0) || (state == HDR1) ||
                                (state == DATA) || (state == CSUM));
  assign xfer         = bus.in_valid && bus.in_ready;
  assign bus.mem_we   = (state == WRITE);
  assign bus.mem_addr = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign cpu_rst_n    = (state == DONE);
  assign done         = (state == DONE);
  assign error        = (state == ERROR);
  assign words_loaded = word_idx;

  // main loader FSM: header capture, length check, word assembly and write
  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= HDR0;
      len      <= 16'd0;
      word_idx <= 16'd0;
      byte_idx <= 2'd0;
      asm_q    <= 24'd0;
      addr_q   <= 32'd0;
      wdata_q  <= 32'd0;
`ifdef LOADER_CHECKSUM_EN
      csum     <= 8'd0;
`endif
    end else begin
      case (state)
        HDR0: begin
          if (xfer) begin
            len[7:0] <= bus.in_data;
            state    <= HDR1;
          end
        end
        HDR1: begin
          if (xfer) begin
            len[15:8] <= bus.in_data;
            state     <= LENCHK;
          end
        end
        LENCHK: begin
          if ((len == 16'd0) || (len > MAX_LEN)) begin
            state <= ERROR;
          end else begin
            state    <= DATA;
            word_idx <= 16'd0;
            byte_idx <= 2'd0;
`ifdef LOADER_CHECKSUM_EN
            csum     <= 8'd0;
`endif
          end
        end
        DATA: begin
          if (xfer) begin
`ifdef LOADER_CHECKSUM_EN
            csum <= csum ^ bus.in_data;
`endif
            if (byte_idx == 2'd3) begin
              // 4th byte goes straight into the top lane; the write port is registered here
              addr_q   <= {14'd0, word_idx, 2'b00};
              wdata_q  <= {bus.in_data, asm_q};
              byte_idx <= 2'd0;
              state    <= WRITE;
            end else begin
              asm_q    <= {bus.in_data, asm_q[23:8]};
              byte_idx <= byte_idx + 2'd1;
            end
          end
        end
        WRITE: begin
          word_idx <= word_idx + 16'd1;
          if ((word_idx + 16'd1) == len) begin
`ifdef LOADER_CHECKSUM_EN
            state <= CSUM;
`else
            state <= DONE;
`endif
          end else begin
            state <= DATA;
          end
        end
        CSUM: begin
`ifdef LOADER_CHECKSUM_EN
          if (xfer) begin
            state <= (bus.in_data == csum) ? DONE : ERROR;
          end
`else
          state <= ERROR;
`endif
        end
        DONE:    state <= DONE;
        ERROR:   state <= ERROR;
        default: state <= ERROR;
      endcase
    end
  end

endmodule
